serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 1..32.
REQ-002 Port: CLK  input  1  rising-edge clock for all state.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: START  input  1  request to begin an addition; sampled on CLK rising edge.
REQ-005 Port: A  input  WIDTH  first operand; captured on an accepted START.
REQ-006 Port: B  input  WIDTH  second operand; captured on an accepted START.
REQ-007 Port: CIN  input  1  carry-in; captured on an accepted START.
REQ-008 Port: BUSY  output  1  high while bits are being processed.
REQ-009 Port: DONE  output  1  one-cycle pulse; SUM and CARRY hold a new result.
REQ-010 Port: SUM  output  WIDTH  registered result, A+B+CIN modulo 2^WIDTH.
REQ-011 Port: CARRY  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL add bit-serially, LSB first: one full-adder step per cycle, built from two half-adder stages (SUM = A^B, CARRY = A&B) plus an OR, with the carry held in a carry flip-flop.
REQ-013 FSM states SHALL be IDLE, SHIFT and FINISH; the reset state is IDLE.
REQ-014 In IDLE, START=1 at an edge SHALL load A, B and CIN into internal shift/carry registers, clear the bit counter and move to SHIFT.
REQ-015 In IDLE with START=0, the state SHALL stay IDLE and all outputs SHALL hold.
REQ-016 In SHIFT, each edge SHALL compute one sum bit from the current LSBs and the carry flip-flop.
  - shift the sum bit into the result register from the MSB side
  - shift A and B right by one
  - update the carry flip-flop
  - increment the counter
REQ-017 On the edge that processes bit WIDTH-1, the FSM SHALL move to FINISH and SHALL copy the result register to SUM and the final carry to CARRY.
REQ-018 BUSY SHALL be 1 exactly in SHIFT.
REQ-019 DONE SHALL be 1 exactly in FINISH, for one cycle.
REQ-020 FINISH SHALL return to IDLE on the next edge unconditionally.
REQ-021 Latency: with START accepted at edge 0, DONE SHALL be high during the cycle after edge WIDTH, and BUSY SHALL be high for exactly WIDTH cycles.
REQ-022 START SHALL be ignored in SHIFT and FINISH, with no effect on operands, counter or outputs.
REQ-023 Back-to-back use: the earliest next acceptance is START high on the edge after FINISH, giving a throughput of one result per WIDTH+2 cycles.
REQ-024 SUM and CARRY SHALL change only on the completion edge, and SHALL hold their previous values while a new addition is in SHIFT.
REQ-025 Changes on A, B and CIN after acceptance SHALL NOT affect the result in progress.
REQ-026 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-027 For WIDTH=1, SHIFT SHALL last one cycle and the result SHALL equal a single full-adder evaluation.

Reset
REQ-028 RST=1 SHALL immediately, without waiting for CLK, force the following:
  - state to IDLE
  - BUSY=0, DONE=0
  - SUM=0, CARRY=0
  - internal shift, carry and counter registers to 0
REQ-029 Reset asserted mid-operation SHALL abort the operation with no DONE pulse; the partial result SHALL never appear on SUM.
REQ-030 After RST deasserts, the first START SHALL be accepted on the first rising edge at which START=1.

Verification
REQ-031 WIDTH=8: A=0x01, B=0x01, CIN=0, START pulse -> BUSY high 8 cycles, DONE pulse in cycle 9, SUM=0x02, CARRY=0.
REQ-032 WIDTH=8: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, CARRY=1; then A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, CARRY=1.
REQ-033 WIDTH=8: START held high continuously with A=0x0F, B=0xF0 -> results every 10 cycles, SUM=0xFF, CARRY=0; A changed to 0x00 mid-SHIFT -> result unchanged.
REQ-034 WIDTH=8: RST pulsed at cycle 4 of SHIFT (A=0x55, B=0xAA) -> BUSY=0, SUM=0x00, CARRY=0 at once, no DONE; next START with A=0x03, B=0x05 -> SUM=0x08.
REQ-035 WIDTH=1, all four A/B combinations with CIN=0 -> (SUM,CARRY) = 00, 10, 10, 01, matching half-adder truth table; DONE in cycle 2 after each START.
REQ-036 Random regression, WIDTH=8 and WIDTH=16, 1000 operations -> {CARRY,SUM} equals A+B+CIN for every DONE pulse.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Operands are captured on START in IDLE; SUM/CARRY update only on the completion edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);

  // state  | meaning
  // IDLE   | waiting for START, outputs hold
  // SHIFT  | one sum bit computed per cycle
  // FINISH | DONE pulse, SUM/CARRY hold the new result

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  logic             ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
  logic             last_bit;

  // full adder from two half adders plus an OR
  assign ha1_s    = a_sh[0] ^ b_sh[0];
  assign ha1_c    = a_sh[0] & b_sh[0];
  assign ha2_s    = ha1_s ^ c_ff;
  assign ha2_c    = ha1_s & c_ff;
  assign fa_c     = ha1_c | ha2_c;
  assign last_bit = (cnt == LAST);

  always_comb begin
    res_nxt            = res >> 1;
    res_nxt[WIDTH-1]   = ha2_s;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = SHIFT;
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (last_bit) state_nxt = FINISH;
      end
      FINISH: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      c_ff  <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      CARRY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_sh <= A;
            b_sh <= B;
            c_ff <= CIN;
            res  <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c_ff <= fa_c;
          res  <= res_nxt;
          cnt  <= cnt + 1'b1;
          // result registers see only a completed addition
          if (last_bit) begin
            SUM   <= res_nxt;
            CARRY <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 16 and 1: scoreboard queues fed by the stimulus,
// a separate monitor pops and compares on every DONE pulse.
module tb_serial_adder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_d [3];
  logic        cin_d   [3];
  logic [31:0] a_d     [3];
  logic [31:0] b_d     [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        carry_o [3];
  logic [31:0] sum_o   [3];
  logic [32:0] last    [3];

  logic [32:0] q0[$], q1[$], q2[$];
  int          total = 0;
  int          bad   = 0;

  logic        busy8, done8, carry8, busy16, done16, carry16, busy1, done1, carry1;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [0:0]  sum1;

  always #5 CLK = ~CLK;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .START(start_d[0]), .A(a_d[0][7:0]), .B(b_d[0][7:0]),
    .CIN(cin_d[0]), .BUSY(busy8), .DONE(done8), .SUM(sum8), .CARRY(carry8));

  serial_adder #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .START(start_d[1]), .A(a_d[1][15:0]), .B(b_d[1][15:0]),
    .CIN(cin_d[1]), .BUSY(busy16), .DONE(done16), .SUM(sum16), .CARRY(carry16));

  serial_adder #(.WIDTH(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(start_d[2]), .A(a_d[2][0:0]), .B(b_d[2][0:0]),
    .CIN(cin_d[2]), .BUSY(busy1), .DONE(done1), .SUM(sum1), .CARRY(carry1));

  assign busy_o[0] = busy8;   assign done_o[0] = done8;   assign carry_o[0] = carry8;
  assign busy_o[1] = busy16;  assign done_o[1] = done16;  assign carry_o[1] = carry16;
  assign busy_o[2] = busy1;   assign done_o[2] = done1;   assign carry_o[2] = carry1;
  assign sum_o[0]  = {24'd0, sum8};
  assign sum_o[1]  = {16'd0, sum16};
  assign sum_o[2]  = {31'd0, sum1};

  function automatic int wd(input int i);
    return (i == 0) ? 8 : (i == 1) ? 16 : 1;
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input int i, input logic [32:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  // reference: plain integer addition, carry is bit WIDTH of the sum
  function automatic logic [32:0] model(input int i, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [31:0] m;
    logic [32:0] tot;
    int          w;
    w   = wd(i);
    m   = (32'h1 << w) - 32'h1;
    tot = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    return {tot[w], tot[31:0] & m};
  endfunction

  task automatic op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] e;
    int          w, k, bc;
    w = wd(i);
    e = model(i, a, b, c);
    push(i, e);
    @(negedge CLK);
    a_d[i] = a; b_d[i] = b; cin_d[i] = c; start_d[i] = 1'b1;
    @(posedge CLK);
    #1;
    start_d[i] = 1'b0;
    a_d[i] = $urandom; b_d[i] = $urandom; cin_d[i] = 1'($urandom);
    k = 0; bc = 0;
    forever begin
      @(negedge CLK);
      k++;
      if (done_o[i]) break;
      if (busy_o[i]) bc++;
      chk("hold_during_shift", {carry_o[i], sum_o[i]}, last[i]);
      start_d[i] = 1'($urandom);
      a_d[i] = $urandom; b_d[i] = $urandom; cin_d[i] = 1'($urandom);
      if (k > w + 4) begin
        chk("done_timeout", 33'(k), 33'(w + 1));
        break;
      end
    end
    start_d[i] = 1'b0;
    chk("done_latency", 33'(k), 33'(w + 1));
    chk("busy_cycles", 33'(bc), 33'(w));
    last[i] = e;
  endtask

  function automatic logic [32:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 33'h0_FFFF_FFFF;
      1:       return 33'h0;
      default: return {1'b0, 32'($urandom)};
    endcase
  endfunction

  initial begin : monitor
    logic [32:0] e;
    int          n;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        for (int i = 0; i < 3; i++) begin
          if (done_o[i]) begin
            n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
            if (n == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_done dut=%0d actual=1 expected=0 t=%0t", i, $time);
            end else begin
              e = (i == 0) ? q0.pop_front() : (i == 1) ? q1.pop_front() : q2.pop_front();
              chk("result", {carry_o[i], sum_o[i]}, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) begin
      start_d[i] = 1'b0; cin_d[i] = 1'b0; a_d[i] = '0; b_d[i] = '0; last[i] = '0;
    end
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 33'(busy_o[i]), 33'd0);
      chk("reset_done", 33'(done_o[i]), 33'd0);
      chk("reset_result", {carry_o[i], sum_o[i]}, 33'd0);
    end
    RST = 1'b0;

    op(0, 32'h01, 32'h01, 1'b0);
    chk("dir_1p1", {carry_o[0], sum_o[0]}, 33'h0_0000_0002);
    op(0, 32'hFF, 32'h01, 1'b0);
    chk("dir_ffp1", {carry_o[0], sum_o[0]}, 33'h1_0000_0000);
    op(0, 32'hFF, 32'hFF, 1'b1);
    chk("dir_ffpffc", {carry_o[0], sum_o[0]}, 33'h1_0000_00FF);

    // START held high: a result every WIDTH+2 cycles, late operand changes ignored
    @(negedge CLK);
    a_d[0] = 32'h0F; b_d[0] = 32'hF0; cin_d[0] = 1'b0; start_d[0] = 1'b1;
    repeat (3) push(0, 33'h0_0000_00FF);
    for (int e = 0; e < 30; e++) begin
      @(posedge CLK);
      #1;
      if (e == 3) a_d[0] = 32'h00;
      if (e == 8) a_d[0] = 32'h0F;
      chk("held_done", 33'(done_o[0]), 33'((e % 10) == 8));
      chk("held_busy", 33'(busy_o[0]), 33'((e % 10) < 8));
    end
    start_d[0] = 1'b0;
    last[0] = 33'h0_0000_00FF;

    // reset in the middle of SHIFT aborts without DONE and clears the result
    @(negedge CLK);
    a_d[0] = 32'h55; b_d[0] = 32'hAA; start_d[0] = 1'b1;
    @(posedge CLK);
    #1 start_d[0] = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_busy", 33'(busy_o[0]), 33'd0);
    chk("rst_done", 33'(done_o[0]), 33'd0);
    chk("rst_result", {carry_o[0], sum_o[0]}, 33'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) last[i] = '0;
    op(0, 32'h03, 32'h05, 1'b0);
    chk("after_rst", {carry_o[0], sum_o[0]}, 33'h0_0000_0008);

    for (int n = 0; n < 4; n++) op(2, 32'(n & 1), 32'(n >> 1), 1'b0);
    for (int n = 0; n < 4; n++) op(2, 32'(n & 1), 32'(n >> 1), 1'b1);

    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          op(0, rnd_operand(), rnd_operand(), 1'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          op(1, rnd_operand(), rnd_operand(), 1'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
      end
      begin
        for (int n = 0; n < 200; n++) op(2, rnd_operand(), rnd_operand(), 1'($urandom));
      end
    join

    repeat (4) @(negedge CLK);
    chk("sb_empty8", 33'(q0.size()), 33'd0);
    chk("sb_empty16", 33'(q1.size()), 33'd0);
    chk("sb_empty1", 33'(q2.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
